truth_table_probe: RTL

- Sequential characterizer for 3-input combinational logic blocks from the 3-input-case truth-table set.
- Drives all eight input combinations in order into a device under test (DUT) and samples the DUT output after each settles.
- Assembles the measured 8-bit truth-table code in the same hex naming used for those blocks (e.g. 0x43) and compares it against an expected code.
- Used in benches and on-chip self-check to confirm that a synthesized gate matches its intended function.

---
 rtl/truth_table_probe.sv | 109 ++++++++++
 1 files changed

// File: rtl/truth_table_probe.sv
// Sweeps the eight input rows of a 3-input combinational block, samples its output
// per row and assembles the 8-bit truth-table code (row 000 -> MSB), compared to an expected code.
module truth_table_probe #(
  parameter int SETTLE_CYCLES = 4,
  parameter int ROW_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  output logic       probe_in1,
  output logic       probe_in2,
  output logic       probe_in3,
  input  logic       probe_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match,
  output logic       unstable
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  localparam logic [ROW_W-1:0] PRE_CNT  = ROW_W'(SETTLE_CYCLES - 1);
  localparam logic [ROW_W-1:0] LAST_CNT = ROW_W'(SETTLE_CYCLES);
  localparam logic [ROW_W-1:0] CNT_ONE  = {{(ROW_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [2:0]       row;
  logic [ROW_W-1:0] cnt;
  logic             pre;
  logic [7:0]       exp_q;
  logic [7:0]       tbl_nxt;
  logic             row_end;

  assign row_end = (state == S_DRIVE) && (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DRIVE;
      S_DRIVE: if (row_end && row == 3'd7) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Table with the current row's final sample merged in, so match can be
  // registered on the same edge that completes the sweep.
  always_comb begin
    tbl_nxt = table_out;
    if (row_end) tbl_nxt[3'd7 - row] = probe_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= 3'd0;
      cnt       <= '0;
      pre       <= 1'b0;
      exp_q     <= 8'h00;
      table_out <= 8'h00;
      match     <= 1'b0;
      unstable  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            exp_q     <= expected;
            table_out <= 8'h00;
            match     <= 1'b0;
            unstable  <= 1'b0;
            row       <= 3'd0;
            cnt       <= '0;
          end
        end
        S_DRIVE: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == PRE_CNT) pre <= probe_out;
          if (row_end) begin
            table_out <= tbl_nxt;
            if (probe_out != pre) unstable <= 1'b1;
            if (row == 3'd7) begin
              match <= (tbl_nxt == exp_q);
            end else begin
              row <= row + 3'd1;
              cnt <= '0;
            end
          end
        end
        default: begin
          row <= 3'd0;
          cnt <= '0;
        end
      endcase
    end
  end

  assign busy      = (state == S_DRIVE);
  assign done      = (state == S_DONE);
  assign probe_in1 = busy & row[2];
  assign probe_in2 = busy & row[1];
  assign probe_in3 = busy & row[0];

endmodule
